// File: rtl/store_pkg.sv
// Shared definitions for the store sequencer: state encodings, error codes,
// store opcode and instruction field positions.
package store_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_READ   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ALIGN   = 2'b11;

  localparam logic [3:0] STORE_OPCODE = 4'hA;

  localparam int INSTR_W  = 16;
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int BASE_MSB = 11;
  localparam int BASE_LSB = 9;
  localparam int SRC_MSB  = 8;
  localparam int SRC_LSB  = 6;
  localparam int OFF_MSB  = 5;
  localparam int OFF_LSB  = 0;
  localparam int OFF_W    = OFF_MSB - OFF_LSB + 1;

endpackage

// File: rtl/store_agu.sv
// Address generation for stores: sign-extends the 6-bit offset, adds it to the
// base register (silent wrap-around) and flags word misalignment when enabled.
module store_agu
  import store_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit ALIGN_CHECK = 1'b0
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] addr,
  output logic              misaligned
);

  logic [ADDR_W-1:0] offset_ext;

  assign offset_ext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign addr       = base + offset_ext;
  assign misaligned = ALIGN_CHECK && (addr[1:0] != 2'b00);

endmodule

// File: rtl/store_sequencer.sv
// Multi-cycle store controller: IDLE -> DECODE -> READ -> MEM -> DONE.
// Define STORE_ALIGN_CHECK_EN to reject stores whose address is not word aligned.
module store_sequencer
  import store_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         ADDR_W   = 32,
  parameter int         REG_AW   = 3,
  parameter int         TIMEOUT  = 15,
  parameter logic [3:0] STORE_OP = STORE_OPCODE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instruction,
  output logic [REG_AW-1:0]   rf_raddr1,
  output logic [REG_AW-1:0]   rf_raddr2,
  input  logic [DATA_W-1:0]   rf_rdata1,
  input  logic [DATA_W-1:0]   rf_rdata2,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);

`ifdef STORE_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT);

  state_t             state;
  logic [INSTR_W-1:0] instr_q;
  logic [REG_AW-1:0]  raddr1_q;
  logic [REG_AW-1:0]  raddr2_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic               mem_we_q;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [CNT_W-1:0]   tmo_next;
  logic               err_q;
  logic [1:0]         err_code_q;

  logic [ADDR_W-1:0]  agu_addr;
  logic               misaligned;
  logic               op_illegal;
  logic               decode_err;
  logic               align_err;
  logic [REG_AW-1:0]  base_field;
  logic [REG_AW-1:0]  src_field;

  store_agu #(
    .ADDR_W      (ADDR_W),
    .ALIGN_CHECK (ALIGN_CHECK)
  ) u_agu (
    .base       (rf_rdata1[ADDR_W-1:0]),
    .offset     (instr_q[OFF_MSB:OFF_LSB]),
    .addr       (agu_addr),
    .misaligned (misaligned)
  );

  assign base_field = instr_q[BASE_MSB:BASE_LSB];
  assign src_field  = instr_q[SRC_MSB:SRC_LSB];
  assign op_illegal = (instr_q[OP_MSB:OP_LSB] != STORE_OP);
  assign tmo_next   = tmo_cnt + CNT_W'(1);

  // Decode and alignment faults are reported in the cycle they are detected;
  // the timeout fault is detected on the MEM exit edge and so comes from err_q.
  assign decode_err = (state == ST_DECODE) && op_illegal;
  assign align_err  = (state == ST_READ) && misaligned;

  assign err      = err_q | decode_err | align_err;
  assign err_code = decode_err ? ERR_OPCODE :
                    align_err  ? ERR_ALIGN  : err_code_q;

  // Register addresses must be visible during DECODE so the file returns data in READ.
  assign rf_raddr1 = (state == ST_DECODE && !op_illegal) ? base_field : raddr1_q;
  assign rf_raddr2 = (state == ST_DECODE && !op_illegal) ? src_field  : raddr2_q;

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; the async reset also drops mem_we without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      instr_q     <= '0;
      raddr1_q    <= '0;
      raddr2_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q    <= instruction;
            err_code_q <= ERR_NONE;
            tmo_cnt    <= '0;
            state      <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (op_illegal) begin
            err_code_q <= ERR_OPCODE;
            state      <= ST_IDLE;
          end else begin
            raddr1_q <= base_field;
            raddr2_q <= src_field;
            state    <= ST_READ;
          end
        end

        ST_READ: begin
          if (misaligned) begin
            err_code_q <= ERR_ALIGN;
            state      <= ST_IDLE;
          end else begin
            mem_addr_q  <= agu_addr;
            mem_wdata_q <= rf_rdata2;
            mem_we_q    <= 1'b1;
            tmo_cnt     <= '0;
            state       <= ST_MEM;
          end
        end

        ST_MEM: begin
          // An acknowledge on the final wait cycle still wins over the timeout.
          if (mem_ready) begin
            mem_we_q <= 1'b0;
            state    <= ST_DONE;
          end else if (tmo_next == TMO_LAST) begin
            tmo_cnt    <= tmo_next;
            mem_we_q   <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state      <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
Multi-cycle controller that sequences one store instruction at a time through the execution cycle: decode, register read, address generation, data-memory write.
- Accepts a 16-bit instruction over a valid/ready handshake.
- Drives register-file read addresses and forms the effective address from the returned data.
- Holds a write request to data memory until the memory acknowledges it.
- Sits between instruction fetch/issue and the register-file/data-memory store datapath.

Parameters:
DATA_W, 32, register and memory data width
ADDR_W, 32, data-memory address width
REG_AW, 3, register-file address width
TIMEOUT, 15, max cycles in MEM waiting for mem_ready before error
STORE_OP, 4'hA, opcode value of the store instruction

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (high only in IDLE)
instruction  in  16  [15:12] opcode, [11:9] base reg, [8:6] source reg, [5:0] signed offset
rf_raddr1  out  REG_AW  base register read address
rf_raddr2  out  REG_AW  source register read address
rf_rdata1  in  DATA_W  base register data, valid one cycle after address
rf_rdata2  in  DATA_W  source register data, valid one cycle after address
mem_addr  out  ADDR_W  effective store address
mem_wdata  out  DATA_W  store data
mem_we  out  1  write request, held until acknowledged
mem_ready  in  1  memory write acknowledge
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a store completes
err  out  1  one-cycle pulse on illegal opcode, timeout or misalignment
err_code  out  2  00 none, 01 illegal opcode, 10 timeout, 11 misaligned; held until next accepted instruction

Behaviour:
- Reset values: all outputs 0 except instr_ready = 1. FSM returns to IDLE. Instruction register, address, data and timeout counter are cleared.
- Reset asserted mid-operation aborts the store immediately; mem_we drops asynchronously.
- States and transitions:
  - IDLE: on instr_valid && instr_ready, latch the instruction, clear err_code, go to DECODE.
  - DECODE: if opcode != STORE_OP, pulse err with code 01 and go to IDLE. Otherwise drive rf_raddr1/rf_raddr2 from the latched fields and go to READ.
  - READ: register mem_addr = rf_rdata1[ADDR_W-1:0] + sign-extended offset (modulo 2^ADDR_W, wrap-around silent). Register mem_wdata = rf_rdata2. Go to MEM.
  - MEM: mem_we = 1, with mem_addr and mem_wdata stable.
    - If mem_ready is high this cycle: drop mem_we next cycle, go to DONE.
    - Else increment the timeout counter. When the counter reaches TIMEOUT without mem_ready, drop mem_we, pulse err with code 10, go to IDLE.
    - mem_ready in the same cycle the counter reaches TIMEOUT counts as success.
  - DONE: pulse done for one cycle, go to IDLE.
- Latency: accept to done = 4 cycles when mem_ready is already high on MEM entry. Minimum instruction spacing is 5 cycles.
- instr_valid while busy is ignored; the instruction is not captured.
- mem_ready outside MEM is ignored.
- rf_raddr1/rf_raddr2 hold their values after DECODE until the next DECODE.

Optional Feature:
STORE_ALIGN_CHECK_EN
- Defined: in READ, if the computed address has bits [1:0] != 0, pulse err with code 11 and go to IDLE. mem_we never asserts for that instruction.
- Undefined: no alignment check; any address is written.

Decomposition:
- Shared package store_pkg: state enum (IDLE, DECODE, READ, MEM, DONE), err_code constants, opcode constant, instruction field bit positions.
- One sub-module store_agu: combinational sign extension and address adder, plus the alignment flag. All sequencing stays in store_sequencer.

Test Plan:
1. Reset held 10 ps then released -> instr_ready = 1, busy/mem_we/done/err = 0, FSM in IDLE.
2. instruction 16'hAAAA (base r5 = 0x116, src r2 = 0xDEADBEEF, offset -22), mem_ready tied 1 -> mem_addr = 0x100, mem_wdata = 0xDEADBEEF, one mem_we cycle, done 4 cycles after accept.
3. instruction 16'hCCCC -> no mem_we, err pulse with err_code = 01 in the DECODE cycle, back in IDLE next cycle.
4. Valid store with mem_ready held 0 -> mem_we high for exactly 15 cycles, then err pulse with err_code = 10, mem_we = 0, IDLE. Repeat with mem_ready raised on wait cycle 5 -> done, no err.
5. Reset asserted while in MEM -> mem_we drops without waiting for a clock edge; a second instr_valid during busy (before the reset) is not captured.
6. With STORE_ALIGN_CHECK_EN, base r5 = 0x100, offset -22 (address 0xEA) -> err with err_code = 11, mem_we never asserted. Without the macro -> write to 0xEA.
